// File: rtl/instruction_queue_decoder.sv
// Instruction queue and decoder between fetch and execute.
// A DEPTH-entry FIFO with valid/ready on both sides. The head entry is decoded
// into a one-hot macro-op and register operand fields. A small state machine
// implements conditional-execution (CEX) blocks and tags each popped
// instruction with a skip flag.
module instruction_queue_decoder #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 16,
    parameter bit CEX_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INST_W-1:0]       in_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INST_W-1:0]       out_inst,
    output logic [7:0]              macro_op,
    output logic [2:0]              dst,
    output logic [2:0]              src_a,
    output logic [2:0]              src_b,
    output logic                    byte_inst,
    output logic                    cex_skip,
    input  logic [3:0]              status,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRUE_BLK  = 2'd1,
        FALSE_BLK = 2'd2
    } cex_state_t;

    logic [INST_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic [INST_W-1:0] head;

    cex_state_t        state;
    logic              cond_met;
    logic [2:0]        t_cnt;
    logic [2:0]        f_cnt;
    logic              skip_r;

    logic              head_is_cex;
    logic [3:0]        head_cond;
    logic [2:0]        head_t;
    logic [2:0]        head_f;
    logic              head_cond_true;

    // Condition code evaluation against PSW flags {V,N,Z,C}.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] st);
        logic c, z, n, v;
        c = st[0];
        z = st[1];
        n = st[2];
        v = st[3];
        case (cc)
            4'd0:    cond_eval = z;
            4'd1:    cond_eval = !z;
            4'd2:    cond_eval = c;
            4'd3:    cond_eval = !c;
            4'd4:    cond_eval = n;
            4'd5:    cond_eval = !n;
            4'd6:    cond_eval = v;
            4'd7:    cond_eval = !v;
            4'd8:    cond_eval = c & !z;
            4'd9:    cond_eval = !c | z;
            4'd10:   cond_eval = (n == v);
            4'd11:   cond_eval = (n != v);
            4'd12:   cond_eval = !z & (n == v);
            4'd13:   cond_eval = z | (n != v);
            4'd14:   cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // One-hot macro-op from the 6-bit opcode field.
    function automatic logic [7:0] decode_op(input logic [5:0] op);
        logic [7:0] m;
        m    = '0;
        m[0] = (op[5:3] == 3'b000);
        m[1] = (op[5:3] == 3'b001);
        m[2] = (op[5:2] == 4'b0100);
        m[3] = (op[5:4] == 2'b10) | (op == 6'b010100);
        m[4] = (op[5:4] == 2'b11) | (op == 6'b010101);
        m[5] = (op == 6'b010110);
        m[6] = (op == 6'b010111);
        m[7] = (op[5:3] == 3'b011);
        return m;
    endfunction

    // Handshake, head selection and CEX field extraction.
    always_comb begin
        out_valid      = (count != '0);
        // When full, a pop in the same cycle frees the slot for the push.
        in_ready       = ((count < CW'(DEPTH)) | out_ready) & ~flush;
        push           = in_valid & in_ready;
        pop            = out_valid & out_ready;
        head           = mem[rd_ptr];
        out_inst       = out_valid ? head : '0;
        head_is_cex    = (out_inst[15:10] == 6'b010111);
        head_cond      = out_inst[9:6];
        head_t         = out_inst[5:3];
        head_f         = out_inst[2:0];
        head_cond_true = cond_eval(head_cond, status);
    end

    // Decoded outputs of the head entry; all zero when the queue is empty.
    always_comb begin
        macro_op  = '0;
        dst       = '0;
        src_a     = '0;
        src_b     = '0;
        byte_inst = 1'b0;
        cex_skip  = 1'b0;
        if (out_valid) begin
            macro_op  = decode_op(out_inst[15:10]);
            byte_inst = out_inst[6];
            cex_skip  = skip_r;
            case (out_inst[15:13])
                3'b000: begin
                    dst   = 3'd4;
                    src_a = 3'd7;
                    src_b = 3'd7;
                end
                3'b100, 3'b101: begin
                    dst   = out_inst[2:0];
                    src_a = out_inst[5:3];
                    src_b = out_inst[2:0];
                end
                default: begin
                    dst   = out_inst[2:0];
                    src_a = out_inst[2:0];
                    src_b = out_inst[5:3];
                end
            endcase
        end
    end

    // Storage array; holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_inst;
        end
    end

    // Pointers and occupancy; count distinguishes full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // CEX block state machine; advances on pops, skip flag registered with state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cond_met <= 1'b0;
            t_cnt    <= '0;
            f_cnt    <= '0;
            skip_r   <= 1'b0;
        end else if (flush || !CEX_EN) begin
            state  <= IDLE;
            skip_r <= 1'b0;
        end else if (pop) begin
            case (state)
                IDLE: begin
                    if (head_is_cex) begin
                        cond_met <= head_cond_true;
                        t_cnt    <= head_t;
                        f_cnt    <= head_f;
                        if (head_t != 3'd0) begin
                            state  <= TRUE_BLK;
                            skip_r <= !head_cond_true;
                        end else if (head_f != 3'd0) begin
                            state  <= FALSE_BLK;
                            skip_r <= head_cond_true;
                        end
                    end
                end
                TRUE_BLK: begin
                    t_cnt <= t_cnt - 3'd1;
                    if (t_cnt == 3'd1) begin
                        if (f_cnt != 3'd0) begin
                            state  <= FALSE_BLK;
                            skip_r <= cond_met;
                        end else begin
                            state  <= IDLE;
                            skip_r <= 1'b0;
                        end
                    end
                end
                FALSE_BLK: begin
                    f_cnt <= f_cnt - 3'd1;
                    if (f_cnt == 3'd1) begin
                        state  <= IDLE;
                        skip_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    skip_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_queue_decoder.sv
// Directed, table-driven bench for instruction_queue_decoder.
module tb_instruction_queue_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [7:0]  macro_op;
    logic [2:0]  dst;
    logic [2:0]  src_a;
    logic [2:0]  src_b;
    logic        byte_inst;
    logic        cex_skip;
    logic [3:0]  status;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    instruction_queue_decoder #(.DEPTH(4), .INST_W(16), .CEX_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .macro_op(macro_op), .dst(dst), .src_a(src_a), .src_b(src_b),
        .byte_inst(byte_inst), .cex_skip(cex_skip), .status(status),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [15:0] ii;
        logic        ordy;
        logic [3:0]  st;
        logic        e_ir;
        logic [15:0] e_oi;
        logic [7:0]  e_mop;
        logic        e_skip;
        logic [2:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [3:0] cc;
        logic [3:0] st;
        logic       e_skip;
    } cond_t;

    typedef struct {
        logic [15:0] inst;
        logic [7:0]  mop;
        logic [2:0]  d;
        logic [2:0]  a;
        logic [2:0]  b;
        logic        by;
    } dec_t;

    vec_t  vecs[$];
    cond_t conds[$];
    dec_t  decs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [15:0] ii,
                         input logic ordy, input logic [3:0] st);
        flush     = fl;
        in_valid  = iv;
        in_inst   = ii;
        out_ready = ordy;
        status    = st;
    endtask

    task automatic add(input logic fl, input logic iv, input logic [15:0] ii,
                       input logic ordy, input logic [3:0] st, input logic e_ir,
                       input logic [15:0] e_oi, input logic [7:0] e_mop,
                       input logic e_skip, input logic [2:0] e_cnt);
        vecs.push_back('{fl, iv, ii, ordy, st, e_ir, e_oi, e_mop, e_skip, e_cnt});
    endtask

    initial begin
        drive(1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
        reset = 1'b0;

        // fill and drain
        add(0,1,16'h4000,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        add(0,1,16'h4001,0,4'h0, 1,16'h4000,8'h04,0,3'd1);
        add(0,1,16'h4002,0,4'h0, 1,16'h4000,8'h04,0,3'd2);
        add(0,1,16'h4003,0,4'h0, 1,16'h4000,8'h04,0,3'd3);
        add(0,0,16'h0000,0,4'h0, 0,16'h4000,8'h04,0,3'd4);
        add(0,0,16'h0000,1,4'h0, 1,16'h4000,8'h04,0,3'd4);
        add(0,0,16'h0000,1,4'h0, 1,16'h4001,8'h04,0,3'd3);
        add(0,0,16'h0000,1,4'h0, 1,16'h4002,8'h04,0,3'd2);
        add(0,0,16'h0000,1,4'h0, 1,16'h4003,8'h04,0,3'd1);
        add(0,0,16'h0000,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        // full with simultaneous push and pop
        add(0,1,16'h4004,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        add(0,1,16'h4005,0,4'h0, 1,16'h4004,8'h04,0,3'd1);
        add(0,1,16'h4006,0,4'h0, 1,16'h4004,8'h04,0,3'd2);
        add(0,1,16'h4007,0,4'h0, 1,16'h4004,8'h04,0,3'd3);
        add(0,1,16'h6008,1,4'h0, 1,16'h4004,8'h04,0,3'd4);
        add(0,0,16'h0000,1,4'h0, 1,16'h4005,8'h04,0,3'd4);
        add(0,0,16'h0000,1,4'h0, 1,16'h4006,8'h04,0,3'd3);
        add(0,0,16'h0000,1,4'h0, 1,16'h4007,8'h04,0,3'd2);
        add(0,0,16'h0000,1,4'h0, 1,16'h6008,8'h80,0,3'd1);
        add(0,0,16'h0000,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        // CEX taken (Z=1)
        add(0,1,16'h5C11,0,4'h2, 1,16'h0000,8'h00,0,3'd0);
        add(0,1,16'h4001,0,4'h2, 1,16'h5C11,8'h40,0,3'd1);
        add(0,1,16'h4002,0,4'h2, 1,16'h5C11,8'h40,0,3'd2);
        add(0,1,16'h4003,0,4'h2, 1,16'h5C11,8'h40,0,3'd3);
        add(0,0,16'h0000,1,4'h2, 1,16'h5C11,8'h40,0,3'd4);
        add(0,0,16'h0000,1,4'h2, 1,16'h4001,8'h04,0,3'd3);
        add(0,0,16'h0000,1,4'h2, 1,16'h4002,8'h04,0,3'd2);
        add(0,0,16'h0000,1,4'h2, 1,16'h4003,8'h04,1,3'd1);
        add(0,1,16'h4010,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        add(0,0,16'h0000,1,4'h0, 1,16'h4010,8'h04,0,3'd1);
        // CEX not taken (Z=0)
        add(0,1,16'h5C11,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        add(0,1,16'h4001,0,4'h0, 1,16'h5C11,8'h40,0,3'd1);
        add(0,1,16'h4002,0,4'h0, 1,16'h5C11,8'h40,0,3'd2);
        add(0,1,16'h4003,0,4'h0, 1,16'h5C11,8'h40,0,3'd3);
        add(0,0,16'h0000,1,4'h0, 1,16'h5C11,8'h40,0,3'd4);
        add(0,0,16'h0000,1,4'h0, 1,16'h4001,8'h04,1,3'd3);
        add(0,0,16'h0000,1,4'h0, 1,16'h4002,8'h04,1,3'd2);
        add(0,0,16'h0000,1,4'h0, 1,16'h4003,8'h04,0,3'd1);
        add(0,0,16'h0000,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        // zero T and F counts
        add(0,1,16'h5C00,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        add(0,1,16'h4020,0,4'h0, 1,16'h5C00,8'h40,0,3'd1);
        add(0,0,16'h0000,1,4'h0, 1,16'h5C00,8'h40,0,3'd2);
        add(0,0,16'h0000,1,4'h0, 1,16'h4020,8'h04,0,3'd1);
        add(0,0,16'h0000,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        // flush inside a not-taken true block; the push in the flush cycle is refused
        add(0,1,16'h5C11,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        add(0,1,16'h4001,0,4'h0, 1,16'h5C11,8'h40,0,3'd1);
        add(0,1,16'h4002,0,4'h0, 1,16'h5C11,8'h40,0,3'd2);
        add(0,0,16'h0000,1,4'h0, 1,16'h5C11,8'h40,0,3'd3);
        add(0,0,16'h0000,1,4'h0, 1,16'h4001,8'h04,1,3'd2);
        add(1,1,16'h7777,1,4'h0, 0,16'h4002,8'h04,1,3'd1);
        add(0,1,16'h4030,0,4'h0, 1,16'h0000,8'h00,0,3'd0);
        add(0,0,16'h0000,0,4'h0, 1,16'h4030,8'h04,0,3'd1);
        add(0,0,16'h0000,1,4'h0, 1,16'h4030,8'h04,0,3'd1);
        add(0,0,16'h0000,0,4'h0, 1,16'h0000,8'h00,0,3'd0);

        // condition codes: CEX with T=1, F=0; follower skip = !condition
        conds.push_back('{4'd1,  4'h0, 1'b0});
        conds.push_back('{4'd2,  4'h1, 1'b0});
        conds.push_back('{4'd4,  4'h0, 1'b1});
        conds.push_back('{4'd6,  4'h8, 1'b0});
        conds.push_back('{4'd8,  4'h3, 1'b1});
        conds.push_back('{4'd9,  4'h0, 1'b0});
        conds.push_back('{4'd10, 4'hC, 1'b0});
        conds.push_back('{4'd11, 4'h4, 1'b0});
        conds.push_back('{4'd12, 4'h8, 1'b1});
        conds.push_back('{4'd13, 4'h0, 1'b1});
        conds.push_back('{4'd14, 4'h0, 1'b0});
        conds.push_back('{4'd15, 4'hF, 1'b1});

        // decode vectors
        decs.push_back('{16'h0000, 8'h01, 3'd4, 3'd7, 3'd7, 1'b0});
        decs.push_back('{16'h2445, 8'h02, 3'd5, 3'd5, 3'd0, 1'b1});
        decs.push_back('{16'h4000, 8'h04, 3'd0, 3'd0, 3'd0, 1'b0});
        decs.push_back('{16'h501A, 8'h08, 3'd2, 3'd2, 3'd3, 1'b0});
        decs.push_back('{16'h543F, 8'h10, 3'd7, 3'd7, 3'd7, 1'b0});
        decs.push_back('{16'h5800, 8'h20, 3'd0, 3'd0, 3'd0, 1'b0});
        decs.push_back('{16'h6C81, 8'h80, 3'd1, 3'd1, 3'd0, 1'b0});
        decs.push_back('{16'h8A6B, 8'h08, 3'd3, 3'd5, 3'd3, 1'b1});
        decs.push_back('{16'hC0F2, 8'h10, 3'd2, 3'd2, 3'd6, 1'b1});
        decs.push_back('{16'hA000, 8'h08, 3'd0, 3'd0, 3'd0, 1'b0});

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_inst", 32'(out_inst), 32'd0);
        chk("rst_macro_op", 32'(macro_op), 32'd0);
        chk("rst_cex_skip", 32'(cex_skip), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // cycle-by-cycle vector table
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ii, vecs[i].ordy, vecs[i].st);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_cnt != 3'd0));
            chk($sformatf("v%0d_out_inst", i), 32'(out_inst), 32'(vecs[i].e_oi));
            chk($sformatf("v%0d_macro_op", i), 32'(macro_op), 32'(vecs[i].e_mop));
            chk($sformatf("v%0d_cex_skip", i), 32'(cex_skip), 32'(vecs[i].e_skip));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
        end

        // reset asserted inside a not-taken true block
        @(negedge clk); drive(0, 1, 16'h5C11, 0, 4'h0);
        @(negedge clk); drive(0, 1, 16'h4001, 1, 4'h0);
        @(negedge clk); drive(0, 0, 16'h0000, 0, 4'h0);
        #1;
        chk("mid_in_block_skip", 32'(cex_skip), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_inst", 32'(out_inst), 32'd0);
        chk("mid_rst_cex_skip", 32'(cex_skip), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); drive(0, 1, 16'h4002, 0, 4'h0);
        @(negedge clk); drive(0, 0, 16'h0000, 0, 4'h0);
        #1;
        chk("post_rst_out_inst", 32'(out_inst), 32'h4002);
        chk("post_rst_cex_skip", 32'(cex_skip), 32'd0);
        @(negedge clk); drive(0, 0, 16'h0000, 1, 4'h0);
        @(negedge clk); drive(0, 0, 16'h0000, 0, 4'h0);
        #1;
        chk("post_rst_empty", 32'(count), 32'd0);

        // condition code table
        for (int i = 0; i < conds.size(); i++) begin
            @(negedge clk); drive(0, 1, {6'b010111, conds[i].cc, 3'd1, 3'd0}, 0, 4'h0);
            @(negedge clk); drive(0, 1, 16'h4000, 0, 4'h0);
            @(negedge clk); drive(0, 0, 16'h0000, 1, conds[i].st);
            #1;
            chk($sformatf("cc%0d_cex_self_skip", conds[i].cc), 32'(cex_skip), 32'd0);
            @(negedge clk); drive(0, 0, 16'h0000, 1, 4'h0);
            #1;
            chk($sformatf("cc%0d_follower_skip", conds[i].cc), 32'(cex_skip), 32'(conds[i].e_skip));
            @(negedge clk); drive(0, 0, 16'h0000, 0, 4'h0);
        end

        // decode table
        for (int i = 0; i < decs.size(); i++) begin
            @(negedge clk); drive(0, 1, decs[i].inst, 0, 4'h0);
            @(negedge clk); drive(0, 0, 16'h0000, 1, 4'h0);
            #1;
            chk($sformatf("d%0h_out_inst", decs[i].inst), 32'(out_inst), 32'(decs[i].inst));
            chk($sformatf("d%0h_macro_op", decs[i].inst), 32'(macro_op), 32'(decs[i].mop));
            chk($sformatf("d%0h_dst", decs[i].inst), 32'(dst), 32'(decs[i].d));
            chk($sformatf("d%0h_src_a", decs[i].inst), 32'(src_a), 32'(decs[i].a));
            chk($sformatf("d%0h_src_b", decs[i].inst), 32'(src_b), 32'(decs[i].b));
            chk($sformatf("d%0h_byte_inst", decs[i].inst), 32'(byte_inst), 32'(decs[i].by));
            chk($sformatf("d%0h_cex_skip", decs[i].inst), 32'(cex_skip), 32'd0);
        end
        @(negedge clk); drive(0, 0, 16'h0000, 0, 4'h0);
        #1;
        chk("final_out_valid", 32'(out_valid), 32'd0);
        chk("final_macro_op", 32'(macro_op), 32'd0);
        chk("final_dst", 32'(dst), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
